// File: rtl/dram_ctrl.sv
// Line-granular DRAM model behind a request FIFO: fixed-latency reads and writes,
// one request in flight, read responses held until the cache accepts them.
module dram_ctrl #(
  parameter int B         = 64,
  parameter int ADDR_BITS = 64,
  parameter int LINES     = 256,
  parameter int LATENCY   = 4,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 hc_valid_in,
  output logic                 hc_ready_out,
  input  logic [ADDR_BITS-1:0] hc_addr_in,
  input  logic                 hc_we_in,
  input  logic [B*8-1:0]       hc_value_in,
  output logic                 hc_valid_out,
  input  logic                 hc_ready_in,
  output logic [ADDR_BITS-1:0] hc_addr_out,
  output logic [B*8-1:0]       hc_value_out
);

  localparam int W     = B * 8;
  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = $clog2(LINES);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [LAT_W-1:0]     LAT_INIT  = LAT_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(QDEPTH);
  localparam logic [ADDR_BITS-1:0] LINE_MASK = {{(ADDR_BITS - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                 state;
  logic [LAT_W-1:0]       cnt;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       q_count;

  logic [ADDR_BITS-1:0]   q_addr [QDEPTH];
  logic                   q_we   [QDEPTH];
  logic [W-1:0]           q_data [QDEPTH];
  logic [W-1:0]           mem    [LINES];

  logic [ADDR_BITS-1:0]   cur_addr;
  logic                   cur_we;
  logic [W-1:0]           cur_data;
  logic [IDX_W-1:0]       cur_idx;

  logic push, pop, mem_we;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign hc_ready_out = (q_count < CNT_FULL);
  assign push         = hc_valid_in && hc_ready_out;
  // Popping only from IDLE gives the one idle cycle after every request.
  assign pop          = (state == IDLE) && (q_count != '0);
  assign mem_we       = (state == ACCESS) && (cnt == '0) && cur_we;
  assign cur_idx      = cur_addr[OFF_W +: IDX_W];

  // NOTE: storage arrays carry no reset; their contents are meaningful only once written.
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_addr[wr_ptr] <= hc_addr_in;
      q_we[wr_ptr]   <= hc_we_in;
      q_data[wr_ptr] <= hc_value_in;
    end
    if (mem_we) mem[cur_idx] <= cur_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q_count      <= '0;
      cur_addr     <= '0;
      cur_we       <= 1'b0;
      cur_data     <= '0;
      hc_valid_out <= 1'b0;
      hc_addr_out  <= '0;
      hc_value_out <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            cur_addr <= q_addr[rd_ptr];
            cur_we   <= q_we[rd_ptr];
            cur_data <= q_data[rd_ptr];
            cnt      <= LAT_INIT;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (cur_we) begin
            state <= IDLE;
          end else begin
            hc_value_out <= mem[cur_idx];
            hc_addr_out  <= cur_addr & LINE_MASK;
            hc_valid_out <= 1'b1;
            state        <= RESPOND;
          end
        end
        RESPOND: begin
          if (hc_ready_in) begin
            hc_valid_out <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: a line-array model plus a queue of expected read
// responses, compared in order as the controller delivers them.
module tb_dram_ctrl;

  localparam int B = 64, AW = 64, LINES = 256, LAT = 4, QD = 4, W = B * 8;

  logic          clk_in = 1'b0;
  logic          rst_N_in;
  logic          hc_valid_in, hc_we_in, hc_ready_in;
  logic          hc_ready_out, hc_valid_out;
  logic [AW-1:0] hc_addr_in, hc_addr_out;
  logic [W-1:0]  hc_value_in, hc_value_out;

  dram_ctrl #(.B(B), .ADDR_BITS(AW), .LINES(LINES), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk_in       (clk_in),
    .rst_N_in     (rst_N_in),
    .hc_valid_in  (hc_valid_in),
    .hc_ready_out (hc_ready_out),
    .hc_addr_in   (hc_addr_in),
    .hc_we_in     (hc_we_in),
    .hc_value_in  (hc_value_in),
    .hc_valid_out (hc_valid_out),
    .hc_ready_in  (hc_ready_in),
    .hc_addr_out  (hc_addr_out),
    .hc_value_out (hc_value_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [LINES];
  int           total = 0;
  int           bad   = 0;

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a >> 6) % LINES);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Offer one request from a negedge and hold it until an edge accepts it.
  task automatic send(input logic [AW-1:0] a, input logic we, input logic [W-1:0] d);
    logic acc;
    int   n;
    exp_t e;
    acc = 1'b0;
    n   = 0;
    hc_valid_in = 1'b1;
    hc_addr_in  = a;
    hc_we_in    = we;
    hc_value_in = d;
    while (!acc && n < 100) begin
      acc = hc_ready_out;
      tick();
      n++;
    end
    hc_valid_in = 1'b0;
    check("accept", W'(acc), W'(1'b1));
    if (acc) begin
      if (we) model[idx_of(a)] = d;
      else begin
        e.addr = a & ~64'h3f;
        e.data = model[idx_of(a)];
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!hc_valid_out && cyc < 100) begin
      tick();
      cyc++;
    end
    check("valid_seen", W'(hc_valid_out), W'(1'b1));
  endtask

  // Compare the current response to the scoreboard head, then complete the handshake.
  task automatic take(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=response expected=none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_addr"}, W'(hc_addr_out), W'(e.addr));
      check({tag, "_data"}, hc_value_out, e.data);
    end
    hc_ready_in = 1'b1;
    tick();
    hc_ready_in = 1'b0;
    check({tag, "_clear"}, W'(hc_valid_out), W'(1'b0));
  endtask

  initial begin
    int           c, seen;
    exp_t         h;
    logic [W-1:0] saved;

    hc_valid_in = 1'b0;
    hc_we_in    = 1'b0;
    hc_ready_in = 1'b0;
    hc_addr_in  = '0;
    hc_value_in = '0;
    rst_N_in    = 1'b1;
    #1 rst_N_in = 1'b0;
    repeat (3) tick();
    check("rst_valid", W'(hc_valid_out), W'(1'b0));
    check("rst_addr",  W'(hc_addr_out),  W'(0));
    check("rst_value", hc_value_out,     W'(0));
    check("rst_ready", W'(hc_ready_out), W'(1'b1));
    rst_N_in = 1'b1;
    tick();

    // Write then read with offset bits set; latency measured from acceptance.
    send(64'h1040, 1'b1, {8{64'hA5A5_0000_0000_0001}});
    repeat (10) tick();
    send(64'h1078, 1'b0, '0);
    wait_valid(c);
    check("read_latency", W'(c), W'(LAT + 1));
    take("wr_rd");

    // Preload lines used by later steps.
    for (int i = 0; i < 6; i++)
      send(64'h3000 + 64'(i) * 64'h40, 1'b1, {16{32'hC0DE_0000 + 32'(i)}});
    send(64'h2000, 1'b1, {8{64'h0123_4567_89AB_CDEF}});
    repeat (60) tick();

    // Backpressure: response must hold steady for 7 cycles with ready low.
    send(64'h3085, 1'b0, '0);
    wait_valid(c);
    h = sb[0];
    for (int k = 0; k < 7; k++) begin
      check("hold_valid", W'(hc_valid_out), W'(1'b1));
      check("hold_addr",  W'(hc_addr_out),  W'(h.addr));
      check("hold_data",  hc_value_out,     h.data);
      tick();
    end
    take("hold");

    // Aliasing: 0x4000 maps onto line 0; ready_in high outside RESPOND is ignored.
    send(64'h0000, 1'b1, {8{64'h1111_1111_1111_1111}});
    send(64'h4000, 1'b1, {8{64'h2222_2222_2222_2222}});
    hc_ready_in = 1'b1;
    send(64'h0000, 1'b0, '0);
    wait_valid(c);
    take("alias");

    // FIFO full: one in flight, four queued, sixth held off.
    for (int i = 0; i < 5; i++)
      send(64'h3000 + 64'(i) * 64'h40, 1'b0, '0);
    check("full_ready", W'(hc_ready_out), W'(1'b0));
    hc_valid_in = 1'b1;
    hc_addr_in  = 64'h3140;
    hc_we_in    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("full_hold", W'(hc_ready_out), W'(1'b0));
      tick();
    end
    wait_valid(c);
    take("full_r1");
    check("no_pop_on_hs", W'(hc_ready_out), W'(1'b0));
    send(64'h3140, 1'b0, '0);
    wait_valid(c);
    check("gap_after_hs", W'(c), W'(3));
    for (int i = 2; i <= 6; i++) begin
      if (i > 2) wait_valid(c);
      take($sformatf("full_r%0d", i));
    end

    // Asynchronous reset during the ACCESS of a queued write with two reads behind it.
    saved = model[idx_of(64'h2000)];
    send(64'h2000, 1'b1, {8{64'hDEAD_BEEF_DEAD_BEEF}});
    send(64'h2040, 1'b0, '0);
    send(64'h2080, 1'b0, '0);
    #2 rst_N_in = 1'b0;
    #1;
    check("mid_rst_valid", W'(hc_valid_out), W'(1'b0));
    check("mid_rst_addr",  W'(hc_addr_out),  W'(0));
    check("mid_rst_value", hc_value_out,     W'(0));
    sb.delete();
    model[idx_of(64'h2000)] = saved;
    @(negedge clk_in);
    rst_N_in = 1'b1;
    check("post_rst_ready", W'(hc_ready_out), W'(1'b1));
    seen = 0;
    repeat (20) begin
      tick();
      if (hc_valid_out) seen++;
    end
    check("no_resp_after_rst", W'(seen), W'(0));
    send(64'h2000, 1'b0, '0);
    wait_valid(c);
    take("lost_write");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 The block SHALL have parameter B, default 64, giving the line size in bytes.
REQ-002 The block SHALL have parameter ADDR_BITS, default 64, giving the address width.
REQ-003 The block SHALL have parameter LINES, default 256, giving the number of stored lines; it SHALL be a power of 2.
REQ-004 The block SHALL have parameter LATENCY, default 4, giving the access cycles; it SHALL be at least 1.
REQ-005 The block SHALL have parameter QDEPTH, default 4, giving the request queue entries; it SHALL be a power of 2.
REQ-006 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_N_in, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port hc_valid_in, input, 1 bit: a request is offered by the lowest-level cache.
REQ-009 The block SHALL have port hc_ready_out, output, 1 bit: the block can accept a request this cycle.
REQ-010 The block SHALL have port hc_addr_in, input, ADDR_BITS bits: the request address.
REQ-011 The block SHALL have port hc_we_in, input, 1 bit: 1 = line write (eviction), 0 = line read (miss fill).
REQ-012 The block SHALL have port hc_value_in, input, B*8 bits: the write line data.
REQ-013 The block SHALL have port hc_valid_out, output, 1 bit: read response is valid.
REQ-014 The block SHALL have port hc_ready_in, input, 1 bit: the cache accepts the response.
REQ-015 The block SHALL have port hc_addr_out, output, ADDR_BITS bits: the response line address, with offset bits zero.
REQ-016 The block SHALL have port hc_value_out, output, B*8 bits: the response line data.

Function
REQ-017 Line index SHALL be hc_addr_in[log2(B) +: log2(LINES)]; address bits above the index SHALL be ignored (aliasing); offset bits SHALL be ignored.
REQ-018 A request SHALL be accepted on a rising edge where hc_valid_in and hc_ready_out are both 1; accepted requests SHALL be pushed into a FIFO of QDEPTH entries holding addr, we, and data.
REQ-019 hc_ready_out SHALL be combinational: 1 when the FIFO count is below QDEPTH, 0 when the FIFO is full; it SHALL NOT depend on hc_valid_in.
REQ-020 A push and a pop on the same edge SHALL leave the count unchanged; the FIFO pointers SHALL wrap modulo QDEPTH.
REQ-021 The FSM SHALL have three states: IDLE, ACCESS, RESPOND.
REQ-022 In IDLE with the FIFO non-empty, the block SHALL pop the head on the edge, latch it, load cnt = LATENCY-1, and move to ACCESS; with the FIFO empty it SHALL stay in IDLE.
REQ-023 A request pushed at edge N into an empty FIFO while in IDLE SHALL be popped at edge N+1, not N.
REQ-024 In ACCESS with cnt != 0, the block SHALL decrement cnt.
REQ-025 In ACCESS with cnt == 0 and a write, the block SHALL store the whole line at that edge and return to IDLE; no response SHALL be produced for a write.
REQ-026 In ACCESS with cnt == 0 and a read, the block SHALL register the array line into hc_value_out and the line address into hc_addr_out, set hc_valid_out = 1, and move to RESPOND.
REQ-027 Read latency SHALL therefore be: accepted at edge N on an idle, empty block, hc_valid_out is 1 after edge N+1+LATENCY.
REQ-028 In RESPOND, hc_valid_out, hc_addr_out and hc_value_out SHALL be held stable until an edge with hc_ready_in = 1; on that edge hc_valid_out SHALL clear and the FSM SHALL go to IDLE.
REQ-029 The next queued request SHALL NOT be popped on the handshake edge in REQ-028 (one IDLE cycle minimum between requests).
REQ-030 Requests SHALL be served strictly in acceptance order; a read after a write to the same index SHALL return the written data.
REQ-031 The block SHALL keep accepting requests into the FIFO while in ACCESS or RESPOND until the FIFO is full.
REQ-032 hc_ready_in asserted while not in RESPOND SHALL be ignored.

Reset
REQ-033 While rst_N_in = 0, the block SHALL asynchronously hold: FSM IDLE, FIFO empty (pointers and count 0), cnt 0, hc_valid_out 0, hc_addr_out 0, hc_value_out 0.
REQ-034 hc_ready_out SHALL be 1 after reset.
REQ-035 Reset asserted mid-ACCESS or mid-RESPOND SHALL discard all queued and in-flight requests; a write not yet stored SHALL be lost.
REQ-036 The line storage array SHALL NOT be reset; its contents are undefined until written.

Verification
REQ-037 The bench SHALL cover a write then a read: write addr 0x1040, data {8{64'hA5A5_0000_0000_0001}}, then read 0x1078 -> hc_valid_out after edge N+1+4 of the read acceptance, hc_addr_out = 0x1040, same data.
REQ-038 The bench SHALL cover FIFO full: with LATENCY=4 and hc_ready_in=0, issue 6 back-to-back reads -> 1 popped, 4 queued, hc_ready_out = 0 and the 6th request is held until a response completes.
REQ-039 The bench SHALL cover backpressure: a read response with hc_ready_in low for 7 cycles -> hc_valid_out, address and data constant for those 7 cycles, then clear after the ready edge.
REQ-040 The bench SHALL cover aliasing and order: write 0x0000 = X, write 0x4000 = Y (LINES=256, B=64), read 0x0000 -> returns Y.
REQ-041 The bench SHALL cover reset mid-operation: assert rst_N_in low asynchronously during ACCESS of a queued write plus 2 queued reads -> outputs 0 immediately, hc_ready_out = 1 after release, and no response is produced for the discarded reads.
